// File: rtl/decoder_4to16_if.sv
// Select/decode bundle for decoder_4to16: binary index and enable in, one-hot word and valid out.
interface decoder_4to16_if;
  logic [3:0]  in;
  logic        en;
  logic [15:0] out;
  logic        out_valid;

  modport master (
    output in,
    output en,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  en,
    output out,
    output out_valid
  );
endinterface

// File: rtl/decoder_4to16.sv
// Registered 4-to-16 one-hot decoder with active-high enable; outputs are always registered.
// Defining DECODER_INPUT_REG_EN adds an input capture stage (latency 2 instead of 1).
module decoder_4to16 (
  input logic            clk,
  input logic            rst_n,
  decoder_4to16_if.slave bus
);

  logic [3:0]  in_q;
  logic        en_q;
  logic [15:0] dec;

`ifdef DECODER_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= '0;
      en_q <= 1'b0;
    end else begin
      in_q <= bus.in;
      en_q <= bus.en;
    end
  end
`else
  always_comb begin
    in_q = bus.in;
    en_q = bus.en;
  end
`endif

  // The index is only looked at when enabled, so an unknown index with en=0 cannot reach out.
  always_comb begin
    dec = '0;
    if (en_q) begin
      dec[in_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out       <= dec;
      bus.out_valid <= en_q;
    end
  end

endmodule

// File: tb/tb_decoder_4to16.sv
// Self-checking bench for decoder_4to16: table-driven vectors feeding a latency-aware scoreboard.
module tb_decoder_4to16;

  logic clk = 1'b0;
  logic rst_n;

  decoder_4to16_if bus ();

  decoder_4to16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef DECODER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  i;
    logic [15:0] eo;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] o;
    logic        v;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] i,
                              input logic [15:0] eo, input string name);
    vec_t v;
    v.r = r; v.e = e; v.i = i; v.eo = eo; v.name = name;
    return v;
  endfunction

  // One clock: drive the row, queue what it should produce, then check the output due now.
  task automatic drive(input vec_t v);
    exp_t e;
    exp_t want;
    rst_n   = v.r;
    bus.en  = v.e;
    bus.in  = v.i;
    e.o = v.r ? v.eo : 16'h0000;
    e.v = v.r & v.e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    if (!v.r) begin
      want.o = 16'h0000;
      want.v = 1'b0;
    end
    checks++;
    if (bus.out !== want.o || bus.out_valid !== want.v || $isunknown({bus.out, bus.out_valid})) begin
      errors++;
      $display("FAIL %s: out=%h out_valid=%b, expected out=%h out_valid=%b",
               v.name, bus.out, bus.out_valid, want.o, want.v);
    end
    checks++;
    if (bus.out_valid === 1'b1 ? ($countones(bus.out) != 1) : (bus.out !== 16'h0000)) begin
      errors++;
      $display("FAIL %s_onehot: out=%h out_valid=%b, expected one bit when valid else 0000",
               v.name, bus.out, bus.out_valid);
    end
  endtask

  task automatic flush(input string name);
    for (int k = 0; k < LAT; k++) drive(mk(1'b1, 1'b0, 4'h0, 16'h0000, name));
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  xin;

    for (int k = 1; k < LAT; k++) sb.push_back('{o: 16'h0000, v: 1'b0});

    // Reset held for two edges with en=1, in=5, then release
    drive(mk(1'b0, 1'b1, 4'h5, 16'h0020, "reset0"));
    drive(mk(1'b0, 1'b1, 4'h5, 16'h0020, "reset1"));
    drive(mk(1'b1, 1'b1, 4'h5, 16'h0020, "release0"));
    drive(mk(1'b1, 1'b1, 4'h5, 16'h0020, "release1"));

    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 16'h0000, "dis_in0"));
    vecs.push_back(mk(1'b1, 1'b0, 4'hA, 16'h0000, "dis_inA"));
    w = 16'h0001;
    for (int unsigned k = 0; k < 16; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 4'(k), w, $sformatf("sweep%0d", k)));
      w = {w[14:0], 1'b0};
    end
    vecs.push_back(mk(1'b1, 1'b1, 4'hF, 16'h8000, "act_inF"));
    vecs.push_back(mk(1'b1, 1'b0, 4'h7, 16'h0000, "dis_after_act"));
    vecs.push_back(mk(1'b1, 1'b0, 4'h7, 16'h0000, "dis_hold"));
    vecs.push_back(mk(1'b1, 1'b1, 4'h3, 16'h0008, "en_rise"));
    vecs.push_back(mk(1'b1, 1'b0, 4'h3, 16'h0000, "en_fall"));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 16'h0001, "en_rise0"));

    foreach (vecs[n]) drive(vecs[n]);

    // Mid-sweep reset pulse at index 9, then resume with the current index
    w = 16'h0040;
    for (int unsigned k = 6; k < 16; k++) begin
      if (k == 9) drive(mk(1'b0, 1'b1, 4'h9, 16'h0200, "midrst"));
      drive(mk(1'b1, 1'b1, 4'(k), w, $sformatf("resume%0d", k)));
      w = {w[14:0], 1'b0};
    end

    // Unknown index while disabled must leave out at zero
    xin = 4'bxxxx;
    drive(mk(1'b1, 1'b0, xin, 16'h0000, "xin0"));
    drive(mk(1'b1, 1'b0, xin, 16'h0000, "xin1"));
    flush("flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
